// File: rtl/sw_pkg.sv
// Shared switch types.
//   flit_type_t  : 2-bit flit type carried beside every payload word.
//   osbm_state_t : control states of the output-side buffer manager.
//   ASSERT/NEGATE: readable single-bit drive levels.
package sw_pkg;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    HEAD = 2'b01,
    BODY = 2'b10,
    TAIL = 2'b11
  } flit_type_t;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } osbm_state_t;

  localparam logic ASSERT = 1'b1;
  localparam logic NEGATE = 1'b0;

endpackage

// File: rtl/osbm_fifo.sv
// Output FIFO of the output-side buffer manager.
// Synchronous write, show-ahead read: rdata always shows the head entry
// and reads as all-zero while the FIFO is empty.
//   clk, rst     : clock, asynchronous active-low reset
//   push, wdata  : write request and data (dropped while full)
//   pop          : remove head entry (ignored while empty)
//   rdata        : head entry
//   full, empty  : occupancy flags
//   count        : number of stored entries, 0..DEPTH
module osbm_fifo #(
  parameter int W     = 34,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers are AW bits wide and DEPTH is a power of two, so they wrap
  // mod DEPTH naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; count==0 already marks every entry invalid,
  // and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/osbm.sv
// Output-side buffer manager, one per switch output port.
// Grants one input at a time (round-robin) when the output FIFO has room
// for a maximum-length packet, captures that input's flits up to TAIL and
// drains them downstream with a valid/ready handshake.
//   clk, rst            : clock, asynchronous active-low reset
//   req[NPORT]          : level request per input, held until ack
//   ack[NPORT]          : one-hot single-cycle grant pulse
//   in_type[2*NPORT]    : packed flit type per input, slice i = [2i+1:2i]
//   in_data[DW*NPORT]   : packed flit payload per input
//   out_valid/out_ready : downstream handshake on the FIFO head
//   out_type/out_data   : head flit (NONE/0 while empty)
//   busy                : high while a packet is being captured
module osbm
  import sw_pkg::*;
#(
  parameter int NPORT  = 4,
  parameter int DW     = 32,
  parameter int DEPTH  = 16,
  parameter int MAXPKT = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NPORT-1:0]    req,
  output logic [NPORT-1:0]    ack,
  input  logic [2*NPORT-1:0]  in_type,
  input  logic [DW*NPORT-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [1:0]          out_type,
  output logic [DW-1:0]       out_data,
  output logic                busy
);

  localparam int SW = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int FW = DW + 2;

  if (DEPTH < MAXPKT) begin : g_depth_check
    $error("osbm: DEPTH must be >= MAXPKT");
  end

  osbm_state_t   state, next_state;
  logic [SW-1:0] sel;
  logic [SW-1:0] rr;
  logic [SW-1:0] winner;
  flit_type_t    cur_type;
  logic [DW-1:0] cur_data;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] free;
  logic          fifo_full;
  logic          fifo_empty;
  logic [FW-1:0] fifo_rdata;
  logic          push;
  logic          grant;
  logic          tail_done;

  // First requester found scanning upward from the rr pointer.
  function automatic logic [SW-1:0] rr_pick(input logic [NPORT-1:0] r,
                                            input logic [SW-1:0]    p);
    logic [SW-1:0] g;
    logic          found;
    int            idx;
    g     = p;
    found = 1'b0;
    for (int k = 0; k < NPORT; k++) begin
      idx = (int'(p) + k) % NPORT;
      if (!found && r[idx]) begin
        g     = SW'(idx);
        found = 1'b1;
      end
    end
    return g;
  endfunction

  assign winner   = rr_pick(req, rr);
  assign cur_type = flit_type_t'(in_type[2*sel +: 2]);
  assign cur_data = in_data[DW*sel +: DW];
  assign free     = CW'(DEPTH) - fifo_count;

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    ack        = '0;
    push       = NEGATE;
    grant      = NEGATE;
    tail_done  = NEGATE;
    case (state)
      IDLE: begin
        // rst is folded in so ack stays low while reset is held, even
        // though the FIFO reads empty and req may still be high.
        if (rst && (|req) && (free >= CW'(MAXPKT))) begin
          ack[winner] = ASSERT;
          grant       = ASSERT;
          next_state  = XFER;
        end
      end
      XFER: begin
        // NONE cycles are bubbles inside the packet: nothing is written.
        if (cur_type != NONE) begin
          push = ASSERT;
          if (cur_type == TAIL) begin
            tail_done  = ASSERT;
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sel   <= '0;
      rr    <= '0;
    end else begin
      state <= next_state;
      if (grant) sel <= winner;
      // Priority moves past the input that just finished its packet.
      if (tail_done) rr <= (sel == SW'(NPORT - 1)) ? '0 : sel + SW'(1);
    end
  end

  osbm_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({cur_type, cur_data}),
    .pop   (out_ready),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign out_valid = ~fifo_empty;
  assign out_type  = fifo_rdata[FW-1:DW];
  assign out_data  = fifo_rdata[DW-1:0];
  assign busy      = (state == XFER);

  // The admission rule makes overflow impossible for a well-formed sender;
  // a write while full means the sender broke the MAXPKT contract.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
                                  !(push && fifo_full))
    else $error("osbm: flit written while FIFO full");

endmodule

// File: tb/tb_osbm.sv
module tb_osbm;
  import sw_pkg::*;

  localparam int NPORT  = 4;
  localparam int DW     = 32;
  localparam int DEPTH  = 16;
  localparam int MAXPKT = 8;

  logic                clk;
  logic                rst;
  logic [NPORT-1:0]    req;
  logic [NPORT-1:0]    ack;
  logic [2*NPORT-1:0]  in_type;
  logic [DW*NPORT-1:0] in_data;
  logic                out_valid;
  logic                out_ready;
  logic [1:0]          out_type;
  logic [DW-1:0]       out_data;
  logic                busy;

  int checks   = 0;
  int failures = 0;
  int flit_id  = 0;
  int pkt_len  = 0;
  logic [DW+1:0] exp_q[$];

  osbm #(
    .NPORT  (NPORT),
    .DW     (DW),
    .DEPTH  (DEPTH),
    .MAXPKT (MAXPKT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .ack       (ack),
    .in_type   (in_type),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_type  (out_type),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares every accepted output flit against the scoreboard.
  initial begin
    logic [DW+1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out_unexpected: got %0h expected none",
                   {out_type, out_data});
        end else begin
          e = exp_q.pop_front();
          check("out_flit", {out_type, out_data}, e);
        end
        pkt_len++;
        if (out_type == TAIL) begin
          check("pkt_len_le_maxpkt", 64'(pkt_len <= MAXPKT), 1);
          pkt_len = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_flits();
    in_type = '0;
    in_data = '0;
  endtask

  task automatic drive_flit(input int port, input logic [1:0] t);
    logic [DW-1:0] d;
    clear_flits();
    d = {8'hA5, 8'(port), 16'(flit_id)};
    flit_id++;
    in_type[2*port +: 2] = t;
    in_data[DW*port +: DW] = d;
    if (t != NONE) exp_q.push_back({t, d});
  endtask

  // Request cycle, then n flit cycles; seq slice i is the type of cycle i.
  task automatic run_pkt(input string name, input logic [3:0] reqv,
                         input logic [3:0] exp_ack, input int port,
                         input logic [15:0] seq, input int n,
                         input logic rdy, input int exp_cnt);
    @(negedge clk);
    clear_flits();
    req = reqv;
    #1;
    check({name, "_ack"}, ack, exp_ack);
    check({name, "_idle"}, busy, 0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req = reqv & ~exp_ack;
      out_ready = rdy;
      drive_flit(port, seq[2*i +: 2]);
      #1;
      check({name, "_noack_busy"}, ack, 0);
      check({name, "_busy"}, busy, 1);
      if (exp_cnt >= 0) check({name, "_count"}, dut.fifo_count, exp_cnt);
    end
  endtask

  task automatic drain(input string name);
    @(negedge clk);
    clear_flits();
    req = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #3;
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_empty"}, out_valid, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    clear_flits();
    exp_q.delete();
    pkt_len = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    req = 4'b1111;
    out_ready = 1'b1;
    clear_flits();
    #12;
    check("rst_ack", ack, 0);
    check("rst_valid", out_valid, 0);
    check("rst_type", out_type, NONE);
    check("rst_data", out_data, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    req = '0;
    rst = 1'b1;

    // Single request, 3-flit packet.
    run_pkt("t1", 4'b0001, 4'b0001, 0, 16'({TAIL, BODY, HEAD}), 3, 1'b1, -1);
    drain("t1");

    // Round-robin with all inputs requesting, 2-flit packets.
    do_reset();
    for (int k = 0; k < 5; k++)
      run_pkt("rr", 4'b1111, 4'(1 << (k % 4)), k % 4, 16'({TAIL, HEAD}), 2,
              1'b1, -1);
    drain("rr");

    // Backpressure: two 5-flit packets fill 10 entries, third waits.
    run_pkt("bp1", 4'b0010, 4'b0010, 1, 16'({TAIL, BODY, BODY, BODY, HEAD}),
            5, 1'b0, -1);
    run_pkt("bp2", 4'b0100, 4'b0100, 2, 16'({TAIL, BODY, BODY, BODY, HEAD}),
            5, 1'b0, -1);
    @(negedge clk);
    clear_flits();
    req = 4'b0001;
    out_ready = 1'b0;
    #1;
    check("bp_no_ack", ack, 0);
    check("bp_count10", dut.fifo_count, 10);
    check("bp_head_type", out_type, HEAD);
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("bp_no_ack_pop1", ack, 0);
    @(negedge clk);
    #1;
    check("bp_no_ack_pop2", ack, 0);
    check("bp_count9", dut.fifo_count, 9);
    run_pkt("bp_grant", 4'b0001, 4'b0001, 0, 16'({TAIL, HEAD}), 2, 1'b0, -1);
    drain("bp");

    // Bubbles: NONE,HEAD,NONE,BODY,TAIL writes exactly 3 flits; then a
    // packet with out_ready high pushes and pops together at count 3.
    run_pkt("bub", 4'b0010, 4'b0010, 1,
            16'({TAIL, BODY, NONE, HEAD, NONE}), 5, 1'b0, -1);
    run_pkt("conc", 4'b0100, 4'b0100, 2, 16'({TAIL, BODY, HEAD}), 3, 1'b1, 3);
    @(negedge clk);
    clear_flits();
    req = '0;
    out_ready = 1'b0;
    #1;
    check("conc_count_after", dut.fifo_count, 3);
    drain("conc");

    // Single-flit packet from input 2 leaves rr at 3.
    run_pkt("single", 4'b0100, 4'b0100, 2, 16'(TAIL), 1, 1'b1, -1);
    run_pkt("rst_pre", 4'b1111, 4'b1000, 3, 16'(HEAD), 1, 1'b0, -1);

    // Asynchronous reset mid-packet.
    @(negedge clk);
    clear_flits();
    req = 4'b0111;
    #2;
    rst = 1'b0;
    exp_q.delete();
    pkt_len = 0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ack", ack, 0);
    check("mid_rst_type", out_type, NONE);
    @(negedge clk);
    req = '0;
    rst = 1'b1;
    run_pkt("post_rst", 4'b1010, 4'b0010, 1, 16'({TAIL, HEAD}), 2, 1'b1, -1);
    drain("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/osbm.md
Name: osbm

Overview:
- Output-side buffer manager: one instance per switch output port. It is the counterpart of the input-side buffer manager.
- Arbitrates among input-port requests and returns a one-cycle ack to the winner.
- Captures the winner's flits from the crossbar into a local output FIFO until the TAIL flit.
- Drains the FIFO to the downstream link with a valid/ready handshake.

Parameters:
- NPORT, 4, number of input ports competing for this output.
- DW, 32, flit payload width.
- DEPTH, 16, output FIFO entries (power of two).
- MAXPKT, 8, max flits per packet. A grant is only issued when free entries >= MAXPKT.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- req  in  NPORT  per-input request, level, held until ack seen.
- ack  out  NPORT  one-hot, single-cycle grant pulse.
- in_type  in  2*NPORT  packed flit type per input (slice i = [2i+1:2i]).
- in_data  in  DW*NPORT  packed flit payload per input.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream accepts.
- out_type  out  2  head flit type.
- out_data  out  DW  head flit payload.
- busy  out  1  high while in XFER.

Behaviour:
- Flit types: NONE=00, HEAD=01, BODY=10, TAIL=11. A flit is present iff type != NONE. A single-flit packet carries TAIL only.
- Reset (rst low, asynchronous):
  - state=IDLE, rr pointer=0, FIFO empty (count=0).
  - ack=0, out_valid=0, out_type=NONE, out_data=0, busy=0.
- FSM states IDLE and XFER.
- IDLE:
  - If |req and free >= MAXPKT: pick winner g by round-robin starting at rr.
  - Drive ack[g]=1 combinationally this cycle; register sel<=g; next state XFER.
  - Otherwise ack=0 and stay in IDLE.
- XFER:
  - ack=0; busy=1.
  - If in_type[sel] != NONE, write {type,data} of input sel into the FIFO this cycle.
  - If the written type == TAIL: next state IDLE, rr <= (sel+1) mod NPORT.
  - NONE cycles inside a packet are bubbles: no write, stay in XFER.
  - Inputs other than sel are ignored.
- Grant latency: the first flit may arrive in the cycle after ack. No new grant is possible in the cycle the TAIL is written; the earliest re-grant is the next cycle.
- FIFO: synchronous write, show-ahead read.
  - out_valid = (count != 0); out_type/out_data = head entry; out_type=NONE when empty.
  - Pop on out_valid & out_ready.
  - Push and pop in the same cycle leave count unchanged. Pop while empty is ignored.
  - Pointers wrap mod DEPTH. count width = clog2(DEPTH)+1.
- Overflow: cannot occur, because of the MAXPKT admission rule.
  - A write while full is dropped and triggers a simulation assertion (protocol error).
- A flit longer than MAXPKT without TAIL is a protocol error; the bench flags it.
- Reset mid-packet: everything returns to reset values and buffered flits are discarded.
- Parameter constraints: DEPTH >= MAXPKT, checked by an elaboration assertion.

Decomposition:
- Package sw_pkg holds:
  - flit_type_t enum (NONE/HEAD/BODY/TAIL);
  - osbm_state_t (IDLE/XFER);
  - ASSERT/NEGATE constants.
- One sub-module, osbm_fifo: parameterised DW+2 wide, DEPTH deep, with push, pop, full, empty and count ports.
- The arbiter stays inline; it is a small rotate-priority function.

Test Plan:
- Single request: req=0001, free=16 -> ack=0001 for exactly 1 cycle. Then input 0 sends HEAD,BODY,TAIL -> 3 FIFO writes, return to IDLE. With out_ready=1, out_type sequence is 01,10,11.
- Round-robin: req=1111 held, each packet 2 flits -> ack order 0001,0010,0100,1000,0001. No ack pulses while busy=1.
- Backpressure: out_ready=0, DEPTH=16, MAXPKT=8, two 5-flit packets -> count=10, free=6 < 8, so third request gets no ack. out_ready=1 for 2 pops -> free=8, ack issued.
- Bubbles and concurrency: XFER with in_type NONE,HEAD,NONE,BODY,TAIL -> exactly 3 writes. Simultaneous push/pop at count=3 -> count stays 3.
- Async reset mid-packet: assert rst low after HEAD written -> immediately out_valid=0, busy=0, ack=0. After release, req=0010 -> ack=0010 (rr reset to 0, input 0 idle).
- Single-flit packet: input 2 sends TAIL alone -> 1 write, IDLE next cycle, rr=3.
